// File: rtl/legv8_mc_control.sv
// legv8_mc_control
// Multi-cycle control FSM for the LEGv8 datapath. Decodes the latched
// instruction word and sequences fetch, decode, execute, memory and
// write-back over a shared single-port memory with a req/ready handshake.
// Also keeps a retired-instruction counter.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr[31:0]          instruction register contents
//   zero                 ALU zero flag (used in BRANCH)
//   mem_ready            memory completes the current request this cycle
//   mem_req, mem_we      memory request / write enable
//   iord                 0 = PC address, 1 = ALU result address
//   ir_write, pc_write   IR load, PC update
//   pc_src               0 = PC+4, 1 = branch target
//   imm_sel[1:0]         00 D-type, 01 CB-type, 10 B-type
//   alu_src, alu_op[1:0] ALU operand / operation select
//   reg_write, mem_to_reg register write-back controls
//   trap                 illegal opcode seen, held until reset
//   instr_count          retired instructions, wraps
//
// Optional feature: define LEGV8_CBNZ_EN to decode CBNZ as a branch;
// otherwise CBNZ traps like any other illegal opcode.
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | read instruction at PC, load IR and PC+4
// DECODE | classify instr, pick the execution path
// EXEC_R | R-type ALU operation
// WB_R   | write ALU result to register file, retire
// ADDR   | compute base + D-type offset
// MEM_RD | LDUR data read, wait for mem_ready
// MEM_WR | STUR data write, retire on mem_ready
// WB_LD  | write load data to register file, retire
// BRANCH | B / CBZ (/ CBNZ) PC update, retire
// TRAP   | illegal opcode, frozen until reset

module legv8_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       imm_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_LD, S_BRANCH, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  logic [10:0] op11;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic        is_rtype, is_ldur, is_stur, is_cbz, is_cbnz, is_b;

  assign op11 = instr[31:21];
  assign op8  = instr[31:24];
  assign op6  = instr[31:26];

  always_comb begin
    is_rtype = (op11 == 11'b10001011000) || (op11 == 11'b11001011000) ||
               (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
    is_ldur  = (op11 == 11'b11111000010);
    is_stur  = (op11 == 11'b11111000000);
    is_cbz   = (op8 == 8'b10110100);
`ifdef LEGV8_CBNZ_EN
    is_cbnz  = (op8 == 8'b10110101);
`else
    is_cbnz  = 1'b0;
`endif
    is_b     = (op6 == 6'b000101);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // run_q holds off the fetch request for the first clock after
        // reset release so mem_req is low throughout reset.
        mem_req = run_q;
        if (run_q && mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_rtype)                  state_d = S_EXEC_R;
        else if (is_ldur || is_stur)   state_d = S_ADDR;
        else if (is_cbz || is_cbnz || is_b) state_d = S_BRANCH;
        else                           state_d = S_TRAP;
      end
      S_EXEC_R: begin
        alu_op  = 2'b10;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        state_d = is_ldur ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_LD;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        imm_sel  = is_b ? 2'b10 : 2'b01;
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        // Unconditional for B; CBZ on zero, CBNZ on non-zero.
        pc_write = is_b || (is_cbz && zero) || (is_cbnz && !zero);
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign instr_count = cnt_q;

endmodule

// File: doc/legv8_mc_control.md
# legv8_mc_control

- Multi-cycle control FSM for the LEGv8 datapath.
- Decodes the latched instruction word and sequences fetch, decode, execute, memory and write-back over a shared single-port memory with a req/ready handshake.
- Drives every datapath enable, including the immediate-format select consumed by the sign-extend unit.
- Keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  1 = write (STUR), 0 = read
- iord  out  1  0 = address from PC, 1 = address from ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target (fetched-instruction PC + imm<<2)
- imm_sel  out  2  00 D-type, 01 CB-type, 10 B-type
- alu_src  out  1  0 = register, 1 = sign-extended immediate
- alu_op  out  2  00 add, 01 pass B (zero test), 10 decode from opcode
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  write-back source: 1 = memory data
- trap  out  1  illegal opcode seen; sticky until reset
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
States: FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_LD, BRANCH, TRAP.

Decode happens in DECODE on `instr`:
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (bits [31:21]) -> EXEC_R.
- LDUR 11111000010, STUR 11111000000 -> ADDR.
- CBZ 10110100 (bits [31:24]) -> BRANCH.
- B 000101 (bits [31:26]) -> BRANCH.
- Anything else -> TRAP.

State actions and transitions:
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- EXEC_R: alu_src=0, alu_op=10 -> WB_R.
- WB_R: reg_write=1, mem_to_reg=0 -> FETCH; retire.
- ADDR: alu_src=1, imm_sel=00, alu_op=00 -> MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_req=1, iord=1, mem_we=0; stay until mem_ready, then WB_LD.
- WB_LD: reg_write=1, mem_to_reg=1 -> FETCH; retire.
- MEM_WR: mem_req=1, iord=1, mem_we=1; stay until mem_ready, then FETCH; retire on the ready cycle.
- BRANCH:
  - imm_sel = 10 for B, 01 for CBZ; alu_op=01.
  - pc_write = 1 for B, or for CBZ when zero=1; pc_src=1.
  - Go to FETCH; retire whether or not the branch is taken.
- TRAP: all enables 0, trap=1, no retire; leaves only on reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = FETCH, instr_count = 0, trap = 0.
  - All outputs 0, except that mem_req = 1 from the first clock after release.
- Outputs are decoded from the state register (Moore). The only exceptions are ir_write and pc_write in FETCH, and pc_write in BRANCH, which are gated combinationally by mem_ready / zero.
- Latency with zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ/B 3. Each wait cycle (mem_ready=0) adds one.
- mem_req stays high and the address/we outputs stay stable until the cycle mem_ready=1. The request drops or changes on the next cycle.
- Reset asserted mid-request: mem_req drops immediately (asynchronously), no write enable remains active, and the FSM restarts in FETCH.
- instr_count increments on the retiring cycle. It wraps from all-ones to 0 with no flag.
- imm_sel is held at 00 in every state except BRANCH.

## Configuration
- LEGV8_CBNZ_EN:
  - When defined, CBNZ (10110101, bits [31:24]) decodes to BRANCH with imm_sel=01, and pc_write=1 when zero=0.
  - When undefined, CBNZ decodes as illegal -> TRAP.

## Test plan
- Reset release with mem_ready tied 1, instr=ADD (0x8B020020):
  - mem_req=1 in cycle 1.
  - States FETCH, DECODE, EXEC_R, WB_R.
  - reg_write=1 only in cycle 4; instr_count=1 after 4 cycles.
- LDUR (0xF8400000) with mem_ready low for 3 cycles in MEM_RD:
  - mem_req/iord held high for 4 cycles.
  - WB_LD asserts reg_write=1 and mem_to_reg=1.
  - Total 8 cycles.
- CBZ (0xB4000040):
  - zero=1 -> pc_write=1, pc_src=1, imm_sel=01 in BRANCH.
  - zero=0 -> pc_write=0 in BRANCH; instr_count still increments.
- STUR (0xF8000000) with rst_n pulsed low while in MEM_WR with mem_ready=0:
  - mem_req and mem_we drop to 0 during reset.
  - instr_count=0, and the FSM resumes in FETCH.
- Opcode 0xFFFFFFFF:
  - TRAP entered after DECODE; trap=1 and all enables stay 0 for 20 cycles.
  - instr_count unchanged; cleared only by rst_n.
- Counter with CNT_W=4: 16 B instructions (0x14000001) wrap instr_count to 0.
- CBNZ 0xB5000040:
  - With LEGV8_CBNZ_EN defined and zero=0, pc_write=1 in BRANCH.
  - Without the macro, trap=1.
